vertex_frame_loader: RTL
========================

// Module: vertex_frame_loader
// PURPOSE
//  Frame-synchronous vertex buffer that configures the six-edge line-check datapath.
//  Accepts 4 transformed vertices serially from the transform stage over a valid/ready port into a shadow bank.
//  Copies the complete shadow bank to the active vtx1..vtx4 outputs only at a frame boundary,
//  so the edge checkers never see a mixed old/new tetrahedron mid-scan.
//  Counts frame boundaries that arrive with an incomplete shadow bank.
// PARAMETERS
//  W           21  width of each signed vertex coordinate (matches h_cnt_Q/v_cnt_Q)
//  MISS_CNT_W  8   width of saturating missed-frame counter
// PORTS
//  CLK          in   1     system clock, all logic on rising edge
//  rst          in   1     asynchronous, active-high reset
//  frame_start  in   1     1-cycle pulse at first pixel of a frame (h_cnt_Q==0 && v_cnt_Q==0)
//  flush        in   1     discard partial shadow fill
//  in_valid     in   1     vertex word valid
//  in_ready     out  1     loader can accept a vertex this cycle
//  in_X/in_Y/in_Z in W     signed vertex coordinates; vertex order 1,2,3,4
//  vtx1_X..vtx4_Z out W    12 signed active coordinate outputs, registered, to line-check datapath
//  swapped      out  1     1-cycle pulse: active bank was updated this cycle
//  miss_cnt     out  MISS_CNT_W  frames where frame_start found shadow not FULL (saturating)
// BEHAVIOUR
//  Reset (async, rst=1)
//   - state=S_IDLE, cnt=0, shadow and all vtx outputs = 0.
//   - swapped=0, miss_cnt=0, in_ready=0 while rst is high.
//  States
//   - S_IDLE: cnt=0, in_ready=1.
//   - S_FILL: cnt in 1..3, in_ready=1.
//   - S_FULL: 4 vertices held, in_ready=0.
//  Accept
//   - Occurs when in_valid && in_ready at a rising edge: shadow[cnt] <= {in_X,in_Y,in_Z}, cnt <= cnt+1.
//   - IDLE -> FILL on the first accept.
//   - Accept with cnt==3 -> S_FULL, cnt stays 3.
//   - in_valid while in_ready=0 is held off; the word is not consumed.
//  Swap (frame_start sampled while state==S_FULL)
//   - Next edge: vtxN_* <= shadow[N], swapped=1 for one cycle, state -> S_IDLE, cnt -> 0.
//   - Latency: outputs change exactly 1 cycle after the frame_start cycle.
//  Miss (frame_start while IDLE or FILL)
//   - Active outputs held.
//   - miss_cnt += 1, saturating at all-ones.
//   - Partial fill is kept; filling continues.
//  Simultaneous events
//   - frame_start with the 4th accept (state FILL, cnt==3): counts as a miss.
//     The 4th vertex is still stored, state -> S_FULL, and the swap happens at the next frame_start.
//   - flush while IDLE/FILL: cnt -> 0, state -> S_IDLE; an accept in the same cycle is dropped.
//   - flush while FULL without frame_start: cnt -> 0, state -> S_IDLE, no swap.
//   - flush with frame_start while FULL: the swap wins, result S_IDLE.
//  Active bank
//   - Never written except by a swap; values are sign-preserving copies (no truncation, no clamping).
//  Reset mid-fill
//   - Shadow and active cleared, state S_IDLE, next frame outputs remain 0 until a full load.
//  Ready timing
//   - in_ready is a registered function of state only (no combinational path from in_valid).
// TESTING
//  T1
//   - Stimulus: reset, then load (10,20,0),(-5,7,1),(300,-40,2),(0,0,3) back-to-back, pulse frame_start.
//   - Required: vtx1..4 update 1 cycle later, swapped=1 for one cycle, in_ready back to 1.
//  T2
//   - Stimulus: load 2 vertices, pulse frame_start.
//   - Required: outputs unchanged, miss_cnt=1; load 2 more and pulse again -> swap with all 4 correct.
//  T3
//   - Stimulus: 4th accept and frame_start in the same cycle.
//   - Required: no swap, miss_cnt+1, state FULL; next frame_start swaps.
//  T4
//   - Stimulus: FULL, hold in_valid=1 with a 5th word.
//   - Required: in_ready=0, word not consumed; after swap it is accepted as vertex 1.
//  T5
//   - Stimulus: flush after 3 vertices, then load 4 new, then frame_start.
//   - Required: only the new vertices appear; flush+frame_start while FULL still swaps.
//  T6
//   - Stimulus: assert rst asynchronously mid-fill; separately, 300 missed frames.
//   - Required: reset -> all outputs 0 immediately; 300 misses -> miss_cnt saturates at 255.

Source files
------------

// File: rtl/vertex_frame_loader.sv
// vertex_frame_loader: shadow-buffered vertex bank for the line-check datapath.
// Four vertices are filled serially and handed over to the active bank only on a frame boundary.
module vertex_frame_loader #(
  parameter int W          = 21,
  parameter int MISS_CNT_W = 8
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [W-1:0]   in_X,
  input  logic signed [W-1:0]   in_Y,
  input  logic signed [W-1:0]   in_Z,
  output logic signed [W-1:0]   vtx1_X,
  output logic signed [W-1:0]   vtx1_Y,
  output logic signed [W-1:0]   vtx1_Z,
  output logic signed [W-1:0]   vtx2_X,
  output logic signed [W-1:0]   vtx2_Y,
  output logic signed [W-1:0]   vtx2_Z,
  output logic signed [W-1:0]   vtx3_X,
  output logic signed [W-1:0]   vtx3_Y,
  output logic signed [W-1:0]   vtx3_Z,
  output logic signed [W-1:0]   vtx4_X,
  output logic signed [W-1:0]   vtx4_Y,
  output logic signed [W-1:0]   vtx4_Z,
  output logic                  swapped,
  output logic [MISS_CNT_W-1:0] miss_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_FULL
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic signed [W-1:0]     sh_q  [4][3];
  logic signed [W-1:0]     sh_d  [4][3];
  logic signed [W-1:0]     act_q [4][3];
  logic signed [W-1:0]     act_d [4][3];
  logic                    swapped_q, swapped_d;
  logic                    rdy_q, rdy_d;
  logic [MISS_CNT_W-1:0]   miss_q, miss_d;
  logic                    accept;
  logic                    is_full;

  assign is_full = (state_q == S_FULL);
  // A flush in the same cycle wins over a new word, so the word is dropped.
  assign accept  = in_valid && rdy_q && !flush;

  // Next-state: swap beats flush beats accept; the miss counter runs alongside.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    act_d     = act_q;
    swapped_d = 1'b0;
    miss_d    = miss_q;

    if (frame_start && !is_full && (miss_q != '1)) begin
      miss_d = miss_q + 1'b1;
    end

    if (frame_start && is_full) begin
      act_d     = sh_q;
      state_d   = S_IDLE;
      cnt_d     = 2'd0;
      swapped_d = 1'b1;
    end else if (flush) begin
      state_d = S_IDLE;
      cnt_d   = 2'd0;
    end else if (accept) begin
      sh_d[cnt_q][0] = in_X;
      sh_d[cnt_q][1] = in_Y;
      sh_d[cnt_q][2] = in_Z;
      if (cnt_q == 2'd3) begin
        state_d = S_FULL;
      end else begin
        cnt_d   = cnt_q + 2'd1;
        state_d = S_FILL;
      end
    end

    // Ready comes straight from the next state so it is a clean flop output.
    rdy_d = (state_d != S_FULL);
  end

  // All loader state, with every output registered.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 2'd0;
      sh_q      <= '{default: '{default: '0}};
      act_q     <= '{default: '{default: '0}};
      swapped_q <= 1'b0;
      rdy_q     <= 1'b0;
      miss_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      act_q     <= act_d;
      swapped_q <= swapped_d;
      rdy_q     <= rdy_d;
      miss_q    <= miss_d;
    end
  end

  assign in_ready = rdy_q;
  assign swapped  = swapped_q;
  assign miss_cnt = miss_q;

  assign vtx1_X = act_q[0][0];
  assign vtx1_Y = act_q[0][1];
  assign vtx1_Z = act_q[0][2];
  assign vtx2_X = act_q[1][0];
  assign vtx2_Y = act_q[1][1];
  assign vtx2_Z = act_q[1][2];
  assign vtx3_X = act_q[2][0];
  assign vtx3_Y = act_q[2][1];
  assign vtx3_Z = act_q[2][2];
  assign vtx4_X = act_q[3][0];
  assign vtx4_Y = act_q[3][1];
  assign vtx4_Z = act_q[3][2];

endmodule
